// File: rtl/dac_spi_tx.sv
// Mode-0 SPI write master for a 16-bit DAC, with a one-word holding buffer so
// the next sample can be handed over while the current frame is shifting out.
module dac_spi_tx #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_IDLE_CLKS      = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] DATA_IN,
  input  logic        VALID,
  output logic        READY,
  output logic        CS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        BUSY,
  output logic        DONE
);

  localparam int HALF_W = $clog2(2 * CLKS_PER_HALF_BIT) + 1;
  localparam int GAP_W  = (CS_IDLE_CLKS > 1) ? $clog2(CS_IDLE_CLKS) : 1;

  localparam logic [HALF_W-1:0] HALF_RISE = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [HALF_W-1:0] HALF_FALL = HALF_W'(2 * CLKS_PER_HALF_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_IDLE_CLKS - 1);
  localparam logic [4:0]        LAST_BIT  = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t             r_state;
  logic [15:0]        r_buf;
  logic               r_buf_full;
  logic [14:0]        r_shift;     // bits still to be sent after the one on MOSI
  logic [HALF_W-1:0]  r_half_cnt;
  logic [4:0]         r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_cs;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_next;
  logic               w_load;
  logic               w_accept;
  logic [14:0]        w_shift_next;
  logic [HALF_W-1:0]  w_half_next;
  logic [4:0]         w_bit_next;
  logic [GAP_W-1:0]   w_gap_next;
  logic               w_cs_next;
  logic               w_sclk_next;
  logic               w_mosi_next;
  logic               w_busy_next;
  logic               w_done_next;

  assign w_accept = VALID && !r_buf_full;

  // Holding buffer: accepting and loading are mutually exclusive because
  // READY is low whenever the buffer is full.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of every other register, independent of block order.
    if (RESET) begin
      r_buf_full <= 1'b0;
      // NOTE: the data word is reset too, so a discarded sample can never
      // reappear on MOSI after a reset.
      r_buf      <= '0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf      <= DATA_IN;
      r_buf_full <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift_next = r_shift;
    w_half_next  = r_half_cnt;
    w_bit_next   = r_bit_cnt;
    w_gap_next   = r_gap_cnt;
    w_cs_next    = r_cs;
    w_sclk_next  = r_sclk;
    w_mosi_next  = r_mosi;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
          w_shift_next = r_buf[14:0];
          w_half_next  = '0;
          w_bit_next   = '0;
          w_cs_next    = 1'b0;
          w_sclk_next  = 1'b0;
          w_mosi_next  = r_buf[15];
          w_busy_next  = 1'b1;
        end
      end

      ST_SHIFT: begin
        w_half_next = r_half_cnt + 1'b1;
        if (r_half_cnt == HALF_RISE) begin
          w_sclk_next = 1'b1;
        end
        if (r_half_cnt == HALF_FALL) begin
          w_half_next = '0;
          w_sclk_next = 1'b0;
          w_bit_next  = r_bit_cnt + 5'd1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = ST_GAP;
            w_cs_next    = 1'b1;
            w_mosi_next  = 1'b0;
            w_done_next  = 1'b1;
            w_gap_next   = '0;
          end else begin
            // MOSI moves only on falling edges, a full half bit before the rise.
            w_mosi_next  = r_shift[14];
            w_shift_next = {r_shift[13:0], 1'b0};
          end
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
        end else begin
          w_gap_next = r_gap_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_half_cnt <= w_half_next;
      r_bit_cnt  <= w_bit_next;
      r_gap_cnt  <= w_gap_next;
      r_cs       <= w_cs_next;
      r_sclk     <= w_sclk_next;
      r_mosi     <= w_mosi_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign READY = !r_buf_full;
  assign CS    = r_cs;
  assign SCLK  = r_sclk;
  assign MOSI  = r_mosi;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (H=2/gap 2 and H=1/gap 1) checked every
// cycle against a timeline model built from load times and plain arithmetic.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in   [2];
  logic        valid_in [2];
  logic [15:0] data_in  [2];
  logic        ready_o  [2];
  logic        cs_o     [2];
  logic        sclk_o   [2];
  logic        mosi_o   [2];
  logic        busy_o   [2];
  logic        done_o   [2];

  int checks   = 0;
  int failures = 0;
  int hb [2] = '{2, 1};
  int ci [2] = '{2, 1};

  dac_spi_tx #(.CLKS_PER_HALF_BIT(2), .CS_IDLE_CLKS(2)) dut_a (
    .CLOCK(clk), .RESET(rst_in[0]), .DATA_IN(data_in[0]), .VALID(valid_in[0]),
    .READY(ready_o[0]), .CS(cs_o[0]), .SCLK(sclk_o[0]), .MOSI(mosi_o[0]),
    .BUSY(busy_o[0]), .DONE(done_o[0])
  );

  dac_spi_tx #(.CLKS_PER_HALF_BIT(1), .CS_IDLE_CLKS(1)) dut_b (
    .CLOCK(clk), .RESET(rst_in[1]), .DATA_IN(data_in[1]), .VALID(valid_in[1]),
    .READY(ready_o[1]), .CS(cs_o[1]), .SCLK(sclk_o[1]), .MOSI(mosi_o[1]),
    .BUSY(busy_o[1]), .DONE(done_o[1])
  );

  // Reference model: the frame is fully described by its load edge m_l; all
  // outputs follow from (edge - m_l) with divide/modulo arithmetic.
  int          cyc         = 0;
  logic        m_full  [2] = '{1'b0, 1'b0};
  logic        m_active[2] = '{1'b0, 1'b0};
  int          m_l     [2] = '{0, 0};
  logic [15:0] m_word  [2];
  logic [15:0] m_shw   [2];
  logic [15:0] m_sent  [2][512];
  int          m_nsent [2] = '{0, 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst_in[d]) begin
        m_full[d]   <= 1'b0;
        m_active[d] <= 1'b0;
      end else if (m_full[d] && (!m_active[d] || cyc >= m_l[d] + 32 * hb[d] + ci[d])) begin
        m_l[d]      <= cyc + 1;
        m_active[d] <= 1'b1;
        m_shw[d]    <= m_word[d];
        m_full[d]   <= 1'b0;
        if (m_nsent[d] < 512) m_sent[d][m_nsent[d]] <= m_word[d];
        m_nsent[d]  <= m_nsent[d] + 1;
      end else if (valid_in[d] && !m_full[d]) begin
        m_full[d] <= 1'b1;
        m_word[d] <= data_in[d];
      end
    end
  end

  // Expected {CS, SCLK, MOSI, READY, BUSY, DONE} after the most recent edge.
  function automatic logic [5:0] exp_vec(input int d);
    int   r;
    int   idx;
    logic in_f;
    logic [5:0] v;
    r    = cyc - m_l[d];
    in_f = m_active[d] && (r < 32 * hb[d]);
    idx  = in_f ? (15 - r / (2 * hb[d])) : 0;
    v[5] = !in_f;
    v[4] = in_f && ((r % (2 * hb[d])) >= hb[d]);
    v[3] = in_f ? m_shw[d][idx] : 1'b0;
    v[2] = !m_full[d];
    v[1] = m_active[d] && (r < 32 * hb[d] + ci[d]);
    v[0] = m_active[d] && (r == 32 * hb[d]);
    return v;
  endfunction

  function automatic logic [5:0] obs_vec(input int d);
    return {cs_o[d], sclk_o[d], mosi_o[d], ready_o[d], busy_o[d], done_o[d]};
  endfunction

  // Line monitor: decodes frames off the wire (MOSI at each SCLK rise).
  logic        p_sclk  [2];
  logic        p_cs    [2];
  logic [15:0] rx_sh   [2];
  int          rx_nb   [2] = '{0, 0};
  int          low_len [2] = '{0, 0};
  int          high_len[2] = '{0, 0};
  int          n_rx    [2] = '{0, 0};
  int          rises   [2] = '{0, 0};
  int          dones   [2] = '{0, 0};
  logic [15:0] rx_word [2][512];
  int          rx_bits [2][512];
  int          rx_len  [2][512];
  int          rx_gap  [2][512];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      p_sclk[d] <= sclk_o[d];
      p_cs[d]   <= cs_o[d];
      if (done_o[d] === 1'b1) dones[d] <= dones[d] + 1;
      if (cs_o[d] === 1'b0) low_len[d] <= low_len[d] + 1;
      else high_len[d] <= high_len[d] + 1;
      if (cs_o[d] === 1'b0 && p_cs[d] === 1'b1) begin
        if (n_rx[d] < 512) rx_gap[d][n_rx[d]] <= high_len[d];
        high_len[d] <= 0;
        rx_nb[d]    <= 0;
      end
      if (sclk_o[d] === 1'b1 && p_sclk[d] === 1'b0) begin
        rx_sh[d] <= {rx_sh[d][14:0], mosi_o[d]};
        rx_nb[d] <= rx_nb[d] + 1;
        rises[d] <= rises[d] + 1;
      end
      if (cs_o[d] === 1'b1 && p_cs[d] === 1'b0) begin
        if (n_rx[d] < 512) begin
          rx_word[d][n_rx[d]] <= rx_sh[d];
          rx_bits[d][n_rx[d]] <= rx_nb[d];
          rx_len[d][n_rx[d]]  <= low_len[d];
        end
        n_rx[d]    <= n_rx[d] + 1;
        low_len[d] <= 0;
      end
    end
  end

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_in[d]   = 1'b1;
      valid_in[d] = 1'b0;
      data_in[d]  = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec(d) !== 6'b100100) begin
        failures++;
        $display("FAIL reset_hold dut%0d got=%b want=100100", d, obs_vec(d));
      end
      rst_in[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec(d) !== 6'b100100) begin
        failures++;
        $display("FAIL reset_release dut%0d got=%b want=100100", d, obs_vec(d));
      end
    end
  endtask

  task automatic test_single();
    int done_j = -1;
    int ndone  = 0;
    int nlow   = 0;
    int rx0;
    rx0 = n_rx[0];
    valid_in[0] = 1'b1;
    data_in[0]  = 16'hA5C3;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      if (j == 1) valid_in[0] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL single_cycle dut%0d j=%0d got=%b want=%b", d, j, obs_vec(d), exp_vec(d));
        end
      end
      if (done_o[0] === 1'b1) begin
        ndone++;
        if (done_j < 0) done_j = j;
      end
      if (cs_o[0] === 1'b0) nlow++;
      if (j == 1 || j == 2) begin
        checks++;
        if (ready_o[0] !== (j == 2)) begin
          failures++;
          $display("FAIL single_ready j=%0d got=%b want=%b", j, ready_o[0], (j == 2));
        end
      end
    end
    checks++;
    if (done_j != 66 || ndone != 1) begin
      failures++;
      $display("FAIL single_done got_at=%0d count=%0d want_at=66 count=1", done_j, ndone);
    end
    checks++;
    if (nlow != 64) begin
      failures++;
      $display("FAIL single_cs_low got=%0d want=64", nlow);
    end
    checks++;
    if (n_rx[0] - rx0 != 1 || rx_word[0][rx0] !== 16'hA5C3 || rx_bits[0][rx0] != 16 || rx_len[0][rx0] != 64) begin
      failures++;
      $display("FAIL single_frame frames=%0d word=%h bits=%0d len=%0d want 1 a5c3 16 64",
               n_rx[0] - rx0, rx_word[0][rx0], rx_bits[0][rx0], rx_len[0][rx0]);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int rx0;
    rx0 = n_rx[0];
    valid_in[0] = 1'b1;
    data_in[0]  = 16'h0001;
    for (int j = 1; j <= 150; j++) begin
      @(negedge clk);
      if (j == 1) data_in[0] = 16'hFFFE;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL b2b_cycle dut%0d j=%0d got=%b want=%b", d, j, obs_vec(d), exp_vec(d));
        end
      end
      if (done_o[0] === 1'b1) ndone++;
      if (j == 3) begin
        checks++;
        if (ready_o[0] !== 1'b0 || cs_o[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_accept_in_shift ready=%b cs=%b want ready=0 cs=0", ready_o[0], cs_o[0]);
        end
        valid_in[0] = 1'b0;
      end
    end
    checks++;
    if (ndone != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d want=2", ndone);
    end
    checks++;
    if (n_rx[0] - rx0 != 2 || rx_word[0][rx0] !== 16'h0001 || rx_word[0][rx0 + 1] !== 16'hFFFE) begin
      failures++;
      $display("FAIL b2b_words frames=%0d w0=%h w1=%h want 2 0001 fffe",
               n_rx[0] - rx0, rx_word[0][rx0], rx_word[0][rx0 + 1]);
    end
    checks++;
    if (rx_gap[0][rx0 + 1] != 3) begin
      failures++;
      $display("FAIL b2b_cs_gap got=%0d want=3", rx_gap[0][rx0 + 1]);
    end
  endtask

  task automatic test_ignore_while_full();
    int s0;
    int r0;
    s0 = m_nsent[0];
    r0 = n_rx[0];
    valid_in[0] = 1'b1;
    data_in[0]  = 16'($urandom);
    for (int j = 1; j <= 440; j++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL ignore_cycle dut%0d j=%0d got=%b want=%b", d, j, obs_vec(d), exp_vec(d));
        end
      end
      valid_in[0] = (j < 260);
      data_in[0]  = 16'($urandom);
    end
    checks++;
    if (n_rx[0] - r0 != m_nsent[0] - s0) begin
      failures++;
      $display("FAIL ignore_frame_count got=%0d want=%0d", n_rx[0] - r0, m_nsent[0] - s0);
    end
    for (int i = 0; i < m_nsent[0] - s0; i++) begin
      checks++;
      if (rx_word[0][r0 + i] !== m_sent[0][s0 + i]) begin
        failures++;
        $display("FAIL ignore_word idx=%0d got=%h want=%h", i, rx_word[0][r0 + i], m_sent[0][s0 + i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int rises0;
    int dones0;
    int r0;
    int nsclk = 0;
    rises0 = rises[0];
    dones0 = dones[0];
    r0     = n_rx[0];
    valid_in[0] = 1'b1;
    data_in[0]  = 16'($urandom);
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL midrst_cycle dut%0d j=%0d got=%b want=%b", d, j, obs_vec(d), exp_vec(d));
        end
      end
      if (j == 1) data_in[0] = 16'($urandom);
      if (j == 3) valid_in[0] = 1'b0;
    end
    rst_in[0] = 1'b1;
    @(negedge clk);
    rst_in[0] = 1'b0;
    checks++;
    if (obs_vec(0) !== 6'b100100) begin
      failures++;
      $display("FAIL midrst_outputs got=%b want=100100", obs_vec(0));
    end
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL midrst_after j=%0d got=%b want=%b", j, obs_vec(0), exp_vec(0));
      end
      if (sclk_o[0] !== 1'b0) nsclk++;
    end
    checks++;
    if (rises[0] - rises0 != 7 || nsclk != 0) begin
      failures++;
      $display("FAIL midrst_sclk rises=%0d after=%0d want 7 0", rises[0] - rises0, nsclk);
    end
    checks++;
    if (dones[0] != dones0) begin
      failures++;
      $display("FAIL midrst_done got=%0d want=0", dones[0] - dones0);
    end
    checks++;
    if (n_rx[0] - r0 != 1 || rx_bits[0][r0] != 7 || rx_len[0][r0] != 30) begin
      failures++;
      $display("FAIL midrst_partial frames=%0d bits=%0d len=%0d want 1 7 30",
               n_rx[0] - r0, rx_bits[0][r0], rx_len[0][r0]);
    end
  endtask

  task automatic test_fast();
    int   nlow    = 0;
    int   mosi_hi = 0;
    int   rises0;
    int   r0;
    logic prev_low  = 1'b0;
    logic prev_sclk = 1'b0;
    rises0 = rises[1];
    r0     = n_rx[1];
    valid_in[1] = 1'b1;
    data_in[1]  = 16'h8000;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (j == 1) valid_in[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL fast_cycle dut%0d j=%0d got=%b want=%b", d, j, obs_vec(d), exp_vec(d));
        end
      end
      if (cs_o[1] === 1'b0) begin
        nlow++;
        if (mosi_o[1] === 1'b1) mosi_hi++;
        if (prev_low) begin
          checks++;
          if (sclk_o[1] === prev_sclk) begin
            failures++;
            $display("FAIL fast_toggle j=%0d sclk=%b prev=%b", j, sclk_o[1], prev_sclk);
          end
        end
      end
      prev_low  = (cs_o[1] === 1'b0);
      prev_sclk = sclk_o[1];
    end
    checks++;
    if (nlow != 32 || mosi_hi != 2) begin
      failures++;
      $display("FAIL fast_frame cs_low=%0d mosi_high=%0d want 32 2", nlow, mosi_hi);
    end
    checks++;
    if (rises[1] - rises0 != 16 || n_rx[1] - r0 != 1 || rx_word[1][r0] !== 16'h8000) begin
      failures++;
      $display("FAIL fast_rises rises=%0d frames=%0d word=%h want 16 1 8000",
               rises[1] - rises0, n_rx[1] - r0, rx_word[1][r0]);
    end
  endtask

  task automatic test_idle();
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({cs_o[d], sclk_o[d], busy_o[d], done_o[d]} !== 4'b1000) begin
          failures++;
          $display("FAIL idle dut%0d j=%0d cs_sclk_busy_done=%b want=1000", d, j,
                   {cs_o[d], sclk_o[d], busy_o[d], done_o[d]});
        end
      end
    end
  endtask

  task automatic test_random();
    int s0[2];
    int r0[2];
    for (int d = 0; d < 2; d++) begin
      s0[d] = m_nsent[d];
      r0[d] = n_rx[d];
    end
    for (int j = 1; j <= 2200; j++) begin
      for (int d = 0; d < 2; d++) begin
        valid_in[d] = (j <= 2000) && ($urandom_range(3) == 0);
        data_in[d]  = 16'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL random_cycle dut%0d j=%0d got=%b want=%b", d, j, obs_vec(d), exp_vec(d));
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (n_rx[d] - r0[d] != m_nsent[d] - s0[d]) begin
        failures++;
        $display("FAIL random_frames dut%0d got=%0d want=%0d", d, n_rx[d] - r0[d], m_nsent[d] - s0[d]);
      end
      for (int i = 0; i < m_nsent[d] - s0[d]; i++) begin
        checks++;
        if (rx_word[d][r0[d] + i] !== m_sent[d][s0[d] + i] || rx_bits[d][r0[d] + i] != 16 ||
            rx_len[d][r0[d] + i] != 32 * hb[d]) begin
          failures++;
          $display("FAIL random_word dut%0d idx=%0d got=%h bits=%0d len=%0d want=%h 16 %0d", d, i,
                   rx_word[d][r0[d] + i], rx_bits[d][r0[d] + i], rx_len[d][r0[d] + i],
                   m_sent[d][s0[d] + i], 32 * hb[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_while_full();
    test_reset_mid_frame();
    test_fast();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
